y86_insn_encoder: RTL
=====================

# y86_insn_encoder

Byte-serial Y86-64 instruction encoder: the inverse of the fetch-stage instruction decoder. It accepts one decoded instruction per handshake (icode, ifun, rA, rB, valC). It emits the instruction's architectural byte image, one byte per cycle, with a running memory address. It sits between the test/loader path and instruction memory, and writes programs into imem in exactly the format the decoder consumes.

## Interface
- BASE_ADDR, 64'h0, reset value of the address counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  encoder can accept an instruction
- icode  in  4  instruction code
- ifun  in  4  function code
- rA  in  4  register A
- rB  in  4  register B
- valC  in  64  constant word / destination
- addr_load  in  1  load address counter from addr_in (honoured in IDLE only)
- addr_in  in  64  new address
- out_valid  out  1  out_byte valid
- out_ready  in  1  memory accepts byte
- out_byte  out  8  instruction byte
- out_addr  out  64  address of out_byte
- out_last  out  1  final byte of current instruction
- err  out  1  one-cycle pulse: invalid instruction consumed

## Operation
- Validity (identical to decoder):
  - icode 0,1,3,4,5,8,9,A,B require ifun=0.
  - icode 2 (cmovXX) and 7 (jXX): ifun 0..6.
  - icode 6 (OPq): ifun 0..3.
  - icode C..F: invalid.
- Length:
  - halt, nop, ret = 1.
  - cmovXX, OPq, pushq, popq = 2.
  - irmovq, rmmovq, mrmovq = 10.
  - jXX, call = 9.
- Byte image:
  - byte0 = {icode,ifun}.
  - If regids are present: byte1 = {rA',rB'}. rA' = 4'hF for irmovq, else rA. rB' = 4'hF for pushq/popq, else rB.
  - valC follows, little-endian: k-th valC byte = valC[8k+7:8k]. It starts at byte2 (10-byte forms) or byte1 (jXX/call).
- FSM states IDLE, EMIT.
  - IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture the full instruction into a holding register and compute the length. If valid, go to EMIT with idx=0. If invalid, pulse err next cycle, stay IDLE, emit nothing.
  - EMIT: in_ready=0, out_valid=1, out_byte = image[idx], out_last = (idx==len-1).
  - On out_valid&&out_ready: idx++ and address counter++. If out_last, return to IDLE.
- Address counter: 64-bit, wraps mod 2^64. FFFF_FFFF_FFFF_FFFF + 1 → 0, mid-instruction, with no error.
- addr_load in IDLE takes effect next cycle. If addr_load and in_valid occur in the same cycle, the first byte uses addr_in. addr_load is ignored in EMIT.
- Holding register is stable during EMIT; input changes have no effect.
- rst (any state, including mid-instruction): state=IDLE, idx=0, addr=BASE_ADDR, holding register cleared. The partial instruction is dropped and no further bytes are emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, out_byte=0, out_addr=BASE_ADDR, out_last=0, err=0.
- Latency: instruction accepted at edge N; first byte valid in cycle N+1. err is asserted in cycle N+1 for an invalid instruction.
- Throughput with out_ready held high: len+1 cycles per instruction (one IDLE accept cycle).
- out_valid never drops and out_byte/out_addr never change while out_valid && !out_ready (AXI-style stall).
- in_ready depends only on state; there is no combinational path from out_ready.
- All outputs are registered or decoded from registered state only.

## Structure
- Package y86_pkg holds:
  - icode constants (I_HALT … I_POPQ).
  - RNONE = 4'hF.
  - Max-ifun constants for cmov/jXX (6) and OPq (3).
  - Encoded-length constants (1, 2, 9, 10).
- The decoder uses the same package.
- Sub-module y86_insn_len: combinational {icode,ifun} → {valid, len[3:0], has_regids, has_valc}. It is shared with the decoder-side length checker.

## Test plan
- Reset, then irmovq icode=3 rA=0 rB=2 valC=64'h0123456789ABCDEF, out_ready=1 → bytes 30 F2 EF CD AB 89 67 45 23 01 at addrs 0..9; out_last only on 01; next in_ready one cycle later.
- addr_load addr_in=64'h100, then call valC=64'h40 with out_ready toggling 1,0 → 9 bytes 80 40 00×7 at 0x100..0x108; each byte held stable while out_ready=0.
- Back-to-back halt, ret, pushq rA=3 → bytes 00 @0, 90 @1, A0 3F @2–3; each instruction 1 idle cycle apart.
- Invalid inputs icode=6 ifun=4, icode=C, nop ifun=1 → err pulse each, no out_valid, address unchanged.
- addr_load 64'hFFFF_FFFF_FFFF_FFFE, then OPq 60 01 → then rmmovq → 60 @…FE, 01 @…FF, rmmovq byte0 @0 (wrap).
- rst asserted during byte 4 of mrmovq → next cycle out_valid=0, out_addr=BASE_ADDR, in_ready=1; following nop emits 10 @BASE_ADDR.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants and types for the encoder and the fetch-side decoder.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE       = 4'hF;
    localparam logic [3:0] IFUN_MAX_CC = 4'd6;
    localparam logic [3:0] IFUN_MAX_OP = 4'd3;

    localparam logic [3:0] LEN_1  = 4'd1;
    localparam logic [3:0] LEN_2  = 4'd2;
    localparam logic [3:0] LEN_9  = 4'd9;
    localparam logic [3:0] LEN_10 = 4'd10;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } enc_state_t;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
    } insn_t;

endpackage

// File: rtl/y86_insn_len.sv
// Combinational instruction classifier: {icode,ifun} -> validity, encoded length, field presence.
module y86_insn_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic       valid,
    output logic [3:0] len,
    output logic       has_regids,
    output logic       has_valc
);

    always_comb begin
        valid      = 1'b0;
        len        = 4'd0;
        has_regids = 1'b0;
        has_valc   = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                valid = (ifun == 4'd0);
                len   = LEN_1;
            end
            I_RRMOVQ: begin
                valid      = (ifun <= IFUN_MAX_CC);
                len        = LEN_2;
                has_regids = 1'b1;
            end
            I_OPQ: begin
                valid      = (ifun <= IFUN_MAX_OP);
                len        = LEN_2;
                has_regids = 1'b1;
            end
            I_PUSHQ, I_POPQ: begin
                valid      = (ifun == 4'd0);
                len        = LEN_2;
                has_regids = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                valid      = (ifun == 4'd0);
                len        = LEN_10;
                has_regids = 1'b1;
                has_valc   = 1'b1;
            end
            I_JXX: begin
                valid    = (ifun <= IFUN_MAX_CC);
                len      = LEN_9;
                has_valc = 1'b1;
            end
            I_CALL: begin
                valid    = (ifun == 4'd0);
                len      = LEN_9;
                has_valc = 1'b1;
            end
            default: begin
                valid = 1'b0;
                len   = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/y86_insn_encoder.sv
// Byte-serial Y86-64 encoder: takes one decoded instruction, streams its memory image with addresses.
//   state  | meaning
//   S_IDLE | ready for an instruction; address may be reloaded
//   S_EMIT | presenting image[idx] at addr until the last byte is accepted
module y86_insn_encoder
    import y86_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    input  logic        addr_load,
    input  logic [63:0] addr_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic [63:0] out_addr,
    output logic        out_last,
    output logic        err
);

    enc_state_t  state;
    insn_t       hold;
    logic [3:0]  len_q;
    logic        regids_q;
    logic        valc_q;
    logic [3:0]  idx;
    logic [63:0] addr;
    logic        err_q;

    logic        dec_valid;
    logic [3:0]  dec_len;
    logic        dec_regids;
    logic        dec_valc;

    y86_insn_len u_len (
        .icode      (icode),
        .ifun       (ifun),
        .valid      (dec_valid),
        .len        (dec_len),
        .has_regids (dec_regids),
        .has_valc   (dec_valc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hold     <= '0;
            len_q    <= 4'd0;
            regids_q <= 1'b0;
            valc_q   <= 1'b0;
            idx      <= 4'd0;
            addr     <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (addr_load) addr <= addr_in;
                    if (in_valid) begin
                        hold     <= '{icode: icode, ifun: ifun, ra: rA, rb: rB, valc: valC};
                        len_q    <= dec_len;
                        regids_q <= dec_regids;
                        valc_q   <= dec_valc;
                        idx      <= 4'd0;
                        if (dec_valid) state <= S_EMIT;
                        else           err_q <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        addr <= addr + 64'd1;
                        idx  <= idx + 4'd1;
                        if (out_last) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [3:0] ra_enc;
    logic [3:0] rb_enc;
    logic [2:0] k;
    logic [7:0] valc_byte;

    // valC byte index: image offset minus the opcode byte and, if present, the regid byte
    always_comb begin
        ra_enc    = (hold.icode == I_IRMOVQ) ? RNONE : hold.ra;
        rb_enc    = (hold.icode == I_PUSHQ || hold.icode == I_POPQ) ? RNONE : hold.rb;
        k         = idx[2:0] - (regids_q ? 3'd2 : 3'd1);
        valc_byte = valc_q ? hold.valc[{k, 3'b000} +: 8] : 8'h00;
        out_byte  = 8'h00;
        if (state == S_EMIT) begin
            if (idx == 4'd0)                out_byte = {hold.icode, hold.ifun};
            else if (regids_q && idx == 4'd1) out_byte = {ra_enc, rb_enc};
            else                            out_byte = valc_byte;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_EMIT);
    assign out_last  = (state == S_EMIT) && (idx == len_q - 4'd1);
    assign out_addr  = addr;
    assign err       = err_q;

endmodule
